// File: rtl/seq_addsub.sv
// ---------------------------------------------------------------------------
// seq_addsub
//
// Multi-cycle signed adder/subtractor. Accepts two WIDTH-bit two's complement
// operands and produces the sign-extended WIDTH+1-bit result of A+B or A-B.
// The sum is built CHUNK bits per clock, least significant chunk first, with
// a ripple carry held in a register between chunks. Subtraction is done as
// A + ~B + 1: B is inverted and the carry is seeded with 1 when the operands
// are latched.
//
// Parameters:
//   WIDTH     operand width; the result is WIDTH+1 bits
//   CHUNK     bits processed per RUN cycle (1 <= CHUNK <= WIDTH, WIDTH % CHUNK == 0)
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous, active-high reset
//   in_valid   in   A, B and func_val are valid
//   in_ready   out  block can accept operands (only in IDLE, never during Reset)
//   A, B       in   signed operands, WIDTH bits
//   func_val   in   0 = A+B, 1 = A-B
//   out_valid  out  S holds a finished result
//   out_ready  in   consumer takes the result
//   S          out  signed, sign-extended result, WIDTH+1 bits
//   busy       out  high while an operation is running or waiting to be taken
//   ovf        out  result does not fit in WIDTH bits (only with the macro below)
//
// Optional feature:
//   Define SEQ_ADDSUB_OVF_EN to add the ovf output.
// ---------------------------------------------------------------------------
module seq_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             func_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   S,
    output logic             busy
`ifdef SEQ_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("seq_addsub: CHUNK must satisfy 1 <= CHUNK <= WIDTH and divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             last_chunk;
    logic             accept;
    logic             sign_bit;

    // One chunk of the ripple adder. The carry-out of the final chunk is the
    // carry out of bit WIDTH-1, which is exactly what the sign bit needs.
    always_comb begin
        a_chunk    = op_a[cnt * CHUNK +: CHUNK];
        b_chunk    = op_b[cnt * CHUNK +: CHUNK];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        last_chunk = (cnt == CW'(NCHUNK - 1));
        sign_bit   = op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ chunk_sum[CHUNK];
    end

    // Next-state and handshake outputs. in_ready is gated with Reset so that
    // a reset edge can never also look like an accept to the producer.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !Reset;
                accept   = in_valid && !Reset;
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and datapath. S is only written in RUN, so it stays
    // stable through DONE no matter what happens on the inputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
`ifdef SEQ_ADDSUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a  <= A;
                        op_b  <= B ^ {WIDTH{func_val}};
                        carry <= func_val;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    S[cnt * CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    carry                   <= chunk_sum[CHUNK];
                    if (last_chunk) begin
                        cnt      <= '0;
                        S[WIDTH] <= sign_bit;
`ifdef SEQ_ADDSUB_OVF_EN
                        // Top two result bits differ: the value needs all WIDTH+1 bits.
                        ovf      <= sign_bit ^ chunk_sum[CHUNK-1];
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// ---------------------------------------------------------------------------
// tb_seq_addsub
//
// Directed bench for seq_addsub. Four instances share one set of inputs:
//   u_dut  WIDTH=8,  CHUNK=2  (latency 4) - main instance for directed tests
//   u_c8   WIDTH=8,  CHUNK=8  (latency 1)
//   u_c1   WIDTH=8,  CHUNK=1  (latency 8)
//   u_w16  WIDTH=16, CHUNK=4  (latency 4)
// The 8-bit instances see the low byte of the shared operand buses.
// ---------------------------------------------------------------------------
module tb_seq_addsub;

    logic        Clk;
    logic        Reset;
    logic        in_valid;
    logic        func_val;
    logic        out_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;

    wire [3:0]   in_ready_v;
    wire [3:0]   out_valid_v;
    wire [3:0]   busy_v;
    wire [8:0]   s0;
    wire [8:0]   s1;
    wire [8:0]   s2;
    wire [16:0]  s3;
`ifdef SEQ_ADDSUB_OVF_EN
    wire [3:0]   ovf_v;
    logic [3:0]  ovf_cap;
`endif

    int          n_cmp;
    int          n_fail;
    logic [16:0] res_v [4];
    int          lat_v [4];

    seq_addsub #(.WIDTH(8), .CHUNK(2)) u_dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .A(a_in[7:0]), .B(b_in[7:0]), .func_val(func_val), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .S(s0), .busy(busy_v[0])
`ifdef SEQ_ADDSUB_OVF_EN
        , .ovf(ovf_v[0])
`endif
    );

    seq_addsub #(.WIDTH(8), .CHUNK(8)) u_c8 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .A(a_in[7:0]), .B(b_in[7:0]), .func_val(func_val), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .S(s1), .busy(busy_v[1])
`ifdef SEQ_ADDSUB_OVF_EN
        , .ovf(ovf_v[1])
`endif
    );

    seq_addsub #(.WIDTH(8), .CHUNK(1)) u_c1 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .A(a_in[7:0]), .B(b_in[7:0]), .func_val(func_val), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .S(s2), .busy(busy_v[2])
`ifdef SEQ_ADDSUB_OVF_EN
        , .ovf(ovf_v[2])
`endif
    );

    seq_addsub #(.WIDTH(16), .CHUNK(4)) u_w16 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_v[3]),
        .A(a_in), .B(b_in), .func_val(func_val), .out_valid(out_valid_v[3]),
        .out_ready(out_ready), .S(s3), .busy(busy_v[3])
`ifdef SEQ_ADDSUB_OVF_EN
        , .ovf(ovf_v[3])
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [16:0] s_of(input int k);
        case (k)
            0:       return {8'h00, s0};
            1:       return {8'h00, s1};
            2:       return {8'h00, s2};
            default: return s3;
        endcase
    endfunction

    // Waits (bounded) for all instances to be idle, issues one accept, then
    // records each instance's result and latency. A latency of -1 means the
    // result never appeared; callers compare latency, so that shows as a FAIL.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic f);
        logic [3:0] seen;
        for (int i = 0; i < 40 && in_ready_v !== 4'hF; i++) begin
            @(posedge Clk); #1;
        end
        a_in = a; b_in = b; func_val = f; in_valid = 1'b1;
        seen = 4'h0;
        for (int k = 0; k < 4; k++) begin
            lat_v[k] = -1;
            res_v[k] = 'x;
        end
        @(posedge Clk); #1;
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= 20 && seen != 4'hF; cyc++) begin
            @(posedge Clk); #1;
            for (int k = 0; k < 4; k++) begin
                if (out_valid_v[k] === 1'b1 && !seen[k]) begin
                    seen[k]  = 1'b1;
                    lat_v[k] = cyc;
                    res_v[k] = s_of(k);
`ifdef SEQ_ADDSUB_OVF_EN
                    ovf_cap[k] = ovf_v[k];
`endif
                end
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && in_ready_v !== 4'hF; i++) begin
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        n_cmp++; if (in_ready_v !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 0000", in_ready_v); end
        n_cmp++; if (out_valid_v !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0000", out_valid_v); end
        n_cmp++; if (busy_v !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0000", busy_v); end
        n_cmp++; if (s0 !== 9'h000) begin n_fail++; $display("[TB] FAIL reset_s: got %h expected 000", s0); end
        n_cmp++; if (s3 !== 17'h00000) begin n_fail++; $display("[TB] FAIL reset_s_w16: got %h expected 00000", s3); end
        Reset = 1'b0;
        #1;
        n_cmp++; if (in_ready_v !== 4'hF) begin n_fail++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1111", in_ready_v); end
        @(posedge Clk); #1;
    endtask

    task automatic test_add_basic();
        int lat;
        wait_idle();
        a_in = 16'h0005; b_in = 16'h0003; func_val = 1'b0; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid_v[0] !== 1'b1 && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
        n_cmp++; if (lat !== 4) begin n_fail++; $display("[TB] FAIL add_latency: got %0d expected 4", lat); end
        n_cmp++; if (s0 !== 9'h008) begin n_fail++; $display("[TB] FAIL add_result: got %h expected 008", s0); end
        n_cmp++; if (busy_v[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL add_busy_done: got %b expected 1", busy_v[0]); end
        @(posedge Clk); #1;
        n_cmp++; if (in_ready_v[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL add_ready_after: got %b expected 1", in_ready_v[0]); end
        n_cmp++; if (out_valid_v[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL add_valid_after: got %b expected 0", out_valid_v[0]); end
    endtask

    task automatic test_sub();
        logic [15:0] va [2];
        logic [15:0] vb [2];
        logic [8:0]  vs [2];
        logic        vo [2];
        va[0] = 16'h0003; vb[0] = 16'h0005; vs[0] = 9'h1FE; vo[0] = 1'b0;
        va[1] = 16'h0080; vb[1] = 16'h0001; vs[1] = 9'h17F; vo[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], vb[i], 1'b1);
            n_cmp++; if (res_v[0][8:0] !== vs[i]) begin n_fail++; $display("[TB] FAIL sub_result[%0d]: got %h expected %h", i, res_v[0][8:0], vs[i]); end
            n_cmp++; if (lat_v[0] !== 4) begin n_fail++; $display("[TB] FAIL sub_latency[%0d]: got %0d expected 4", i, lat_v[0]); end
`ifdef SEQ_ADDSUB_OVF_EN
            n_cmp++; if (ovf_cap[0] !== vo[i]) begin n_fail++; $display("[TB] FAIL sub_ovf[%0d]: got %b expected %b", i, ovf_cap[0], vo[i]); end
`else
            if (vo[i] !== 1'b0 && vo[i] !== 1'b1) $display("[TB] note: bad ovf table entry");
`endif
        end
    endtask

    task automatic test_sign_ext();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [8:0]  vs [3];
        logic        vo [3];
        va[0] = 16'h0080; vb[0] = 16'h0080; vs[0] = 9'h100; vo[0] = 1'b1;
        va[1] = 16'h007F; vb[1] = 16'h0001; vs[1] = 9'h080; vo[1] = 1'b1;
        va[2] = 16'h00FF; vb[2] = 16'h0001; vs[2] = 9'h000; vo[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0);
            n_cmp++; if (res_v[0][8:0] !== vs[i]) begin n_fail++; $display("[TB] FAIL sext_result[%0d]: got %h expected %h", i, res_v[0][8:0], vs[i]); end
`ifdef SEQ_ADDSUB_OVF_EN
            n_cmp++; if (ovf_cap[0] !== vo[i]) begin n_fail++; $display("[TB] FAIL sext_ovf[%0d]: got %b expected %b", i, ovf_cap[0], vo[i]); end
`else
            if (vo[i] !== 1'b0 && vo[i] !== 1'b1) $display("[TB] note: bad ovf table entry");
`endif
        end
    endtask

    task automatic test_backpressure();
        int lat;
        wait_idle();
        out_ready = 1'b0;
        a_in = 16'h0012; b_in = 16'h0034; func_val = 1'b0; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid_v[0] !== 1'b1 && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
        n_cmp++; if (lat !== 4) begin n_fail++; $display("[TB] FAIL bp_latency: got %0d expected 4", lat); end
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            n_cmp++; if (out_valid_v[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", i, out_valid_v[0]); end
            n_cmp++; if (s0 !== 9'h046) begin n_fail++; $display("[TB] FAIL bp_result[%0d]: got %h expected 046", i, s0); end
            n_cmp++; if (in_ready_v[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready_v[0]); end
        end
        out_ready = 1'b1;
        @(posedge Clk); #1;
        n_cmp++; if (out_valid_v[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_release_valid: got %b expected 0", out_valid_v[0]); end
        n_cmp++; if (in_ready_v[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready_v[0]); end
    endtask

    task automatic test_input_isolation();
        int lat;
        wait_idle();
        a_in = 16'h0021; b_in = 16'h000F; func_val = 1'b1; in_valid = 1'b1;
        @(posedge Clk); #1;
        lat = 0;
        while (out_valid_v[0] !== 1'b1 && lat < 20) begin
            a_in     = ~a_in;
            b_in     = b_in + 16'h0013;
            func_val = ~func_val;
            n_cmp++; if (in_ready_v[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL iso_in_ready[%0d]: got %b expected 0", lat, in_ready_v[0]); end
            @(posedge Clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        n_cmp++; if (lat !== 4) begin n_fail++; $display("[TB] FAIL iso_latency: got %0d expected 4", lat); end
        n_cmp++; if (s0 !== 9'h012) begin n_fail++; $display("[TB] FAIL iso_result: got %h expected 012", s0); end
        repeat (2) @(posedge Clk);
        #1;
        n_cmp++; if (busy_v[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL iso_no_second_accept: busy got %b expected 0", busy_v[0]); end
    endtask

    task automatic test_reset_mid();
        wait_idle();
        a_in = 16'h0044; b_in = 16'h0011; func_val = 1'b0; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        #1;
        n_cmp++; if (out_valid_v[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_valid: got %b expected 0", out_valid_v[0]); end
        n_cmp++; if (s0 !== 9'h000) begin n_fail++; $display("[TB] FAIL rmid_s: got %h expected 000", s0); end
        n_cmp++; if (in_ready_v[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_in_ready: got %b expected 1", in_ready_v[0]); end
        n_cmp++; if (busy_v[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy_v[0]); end
        run_op(16'h0010, 16'h0020, 1'b0);
        n_cmp++; if (res_v[0][8:0] !== 9'h030) begin n_fail++; $display("[TB] FAIL rmid_after_result: got %h expected 030", res_v[0][8:0]); end
        n_cmp++; if (lat_v[0] !== 4) begin n_fail++; $display("[TB] FAIL rmid_after_latency: got %0d expected 4", lat_v[0]); end
    endtask

    task automatic test_config_sweep();
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic        vf [8];
        logic [8:0]  e8;
        logic [16:0] e16;
        int          elat [4];
        va[0] = 16'h1234; vb[0] = 16'h0F0F; vf[0] = 1'b0;
        va[1] = 16'h8000; vb[1] = 16'h7FFF; vf[1] = 1'b1;
        va[2] = 16'hFFFF; vb[2] = 16'hFFFF; vf[2] = 1'b0;
        va[3] = 16'h7FFF; vb[3] = 16'h8000; vf[3] = 1'b1;
        va[4] = 16'hA5C3; vb[4] = 16'h5A3C; vf[4] = 1'b0;
        va[5] = 16'h00FF; vb[5] = 16'h0001; vf[5] = 1'b1;
        va[6] = 16'h8001; vb[6] = 16'h8001; vf[6] = 1'b0;
        va[7] = 16'h4321; vb[7] = 16'hC0DE; vf[7] = 1'b1;
        elat[0] = 4; elat[1] = 1; elat[2] = 8; elat[3] = 4;
        for (int i = 0; i < 8; i++) begin
            if (vf[i]) begin
                e8  = {va[i][7], va[i][7:0]} - {vb[i][7], vb[i][7:0]};
                e16 = {va[i][15], va[i]} - {vb[i][15], vb[i]};
            end else begin
                e8  = {va[i][7], va[i][7:0]} + {vb[i][7], vb[i][7:0]};
                e16 = {va[i][15], va[i]} + {vb[i][15], vb[i]};
            end
            run_op(va[i], vb[i], vf[i]);
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (res_v[k][8:0] !== e8) begin n_fail++; $display("[TB] FAIL sweep_result[%0d] inst %0d: got %h expected %h", i, k, res_v[k][8:0], e8); end
            end
            n_cmp++; if (res_v[3] !== e16) begin n_fail++; $display("[TB] FAIL sweep_result[%0d] inst 3: got %h expected %h", i, res_v[3], e16); end
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (lat_v[k] !== elat[k]) begin n_fail++; $display("[TB] FAIL sweep_latency[%0d] inst %0d: got %0d expected %0d", i, k, lat_v[k], elat[k]); end
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        Reset     = 1'b1;
        in_valid  = 1'b0;
        func_val  = 1'b0;
        out_ready = 1'b1;
        a_in      = 16'h0000;
        b_in      = 16'h0000;
        test_reset();
        test_add_basic();
        test_sub();
        test_sign_ext();
        test_backpressure();
        test_input_isolation();
        test_reset_mid();
        test_config_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
